// File: rtl/step_gen_if.sv
// Command and status bundle for the step generator: command handshake
// plus the step/dir outputs and status flags.
interface step_gen_if #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 31
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_period;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic              abort;
  logic              step;
  logic              dir;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_left;

  modport master (
    output cmd_valid, cmd_period, cmd_steps, cmd_dir, abort,
    input  cmd_ready, step, dir, busy, done, steps_left
  );

  modport slave (
    input  cmd_valid, cmd_period, cmd_steps, cmd_dir, abort,
    output cmd_ready, step, dir, busy, done, steps_left
  );
endinterface

// File: rtl/step_gen.sv
// Step/direction pulse generator with one pending command slot, direction
// setup delay, back-to-back chaining and synchronous abort.
module step_gen #(
  parameter int CNT_W     = 32,
  parameter int STEP_W    = 31,
  parameter int DIR_SETUP = 4
) (
  input logic       clk,
  input logic       reset,
  step_gen_if.slave bus
);

  localparam int SETUP_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [CNT_W-1:0] PE_MIN = CNT_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_ph;
  logic [CNT_W-1:0]    r_pe;
  logic [SETUP_W-1:0]  r_setup_cnt;
  logic [STEP_W-1:0]   r_steps_left;
  logic                r_dir;
  logic                r_step;
  logic                r_done;
  logic                r_pend_valid;
  logic [CNT_W-1:0]    r_pend_pe;
  logic [STEP_W-1:0]   r_pend_steps;
  logic                r_pend_dir;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_ph_nxt;
  logic [CNT_W-1:0]    w_pe_nxt;
  logic [SETUP_W-1:0]  w_setup_nxt;
  logic [STEP_W-1:0]   w_steps_nxt;
  logic                w_dir_nxt;
  logic                w_step_nxt;
  logic                w_done_nxt;
  logic                w_pend_valid_nxt;
  logic                w_load;
  logic                w_xfer;

  assign w_xfer         = bus.cmd_valid && !r_pend_valid && !bus.abort;
  assign bus.cmd_ready  = ~r_pend_valid;
  assign bus.step       = r_step;
  assign bus.dir        = r_dir;
  assign bus.done       = r_done;
  assign bus.steps_left = r_steps_left;
  assign bus.busy       = (r_state != S_IDLE) || r_pend_valid;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt      = r_state;
    w_ph_nxt         = r_ph;
    w_pe_nxt         = r_pe;
    w_setup_nxt      = r_setup_cnt;
    w_steps_nxt      = r_steps_left;
    w_dir_nxt        = r_dir;
    w_pend_valid_nxt = r_pend_valid;
    w_done_nxt       = 1'b0;
    w_load           = 1'b0;

    unique case (r_state)
      S_IDLE:  w_load = r_pend_valid;
      S_SETUP: begin
        if (r_setup_cnt == '0) begin
          w_state_nxt = S_RUN;
          w_ph_nxt    = '0;
        end else begin
          w_setup_nxt = r_setup_cnt - SETUP_W'(1);
        end
      end
      S_RUN: begin
        if (r_ph == r_pe - CNT_W'(1)) begin
          w_ph_nxt    = '0;
          w_steps_nxt = r_steps_left - STEP_W'(1);
          if (r_steps_left == STEP_W'(1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
            w_load      = r_pend_valid;
          end
        end else begin
          w_ph_nxt = r_ph + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Loading a zero-step command completes it on the spot without touching dir.
    if (w_load) begin
      w_pend_valid_nxt = 1'b0;
      w_pe_nxt         = r_pend_pe;
      w_ph_nxt         = '0;
      if (r_pend_steps == '0) begin
        w_state_nxt = S_IDLE;
        w_steps_nxt = '0;
        w_done_nxt  = 1'b1;
      end else begin
        w_steps_nxt = r_pend_steps;
        if (r_pend_dir == r_dir) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_SETUP;
          w_dir_nxt   = r_pend_dir;
          w_setup_nxt = SETUP_W'(DIR_SETUP - 1);
        end
      end
    end

    if (w_xfer) w_pend_valid_nxt = 1'b1;

    if (bus.abort) begin
      w_state_nxt      = S_IDLE;
      w_ph_nxt         = '0;
      w_setup_nxt      = '0;
      w_steps_nxt      = '0;
      w_dir_nxt        = r_dir;
      w_pend_valid_nxt = 1'b0;
      w_done_nxt       = 1'b0;
    end

    w_step_nxt = (w_state_nxt == S_RUN) && (w_ph_nxt < (w_pe_nxt >> 1));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ph         <= '0;
      r_pe         <= PE_MIN;
      r_setup_cnt  <= '0;
      r_steps_left <= '0;
      r_dir        <= 1'b0;
      r_step       <= 1'b0;
      r_done       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_pe    <= PE_MIN;
      r_pend_steps <= '0;
      r_pend_dir   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ph         <= w_ph_nxt;
      r_pe         <= w_pe_nxt;
      r_setup_cnt  <= w_setup_nxt;
      r_steps_left <= w_steps_nxt;
      r_dir        <= w_dir_nxt;
      r_step       <= w_step_nxt;
      r_done       <= w_done_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      if (w_xfer) begin
        r_pend_pe    <= (bus.cmd_period < PE_MIN) ? PE_MIN : bus.cmd_period;
        r_pend_steps <= bus.cmd_steps;
        r_pend_dir   <= bus.cmd_dir;
      end
    end
  end

endmodule

// File: tb/tb_step_gen.sv
// Scenario bench for step_gen: per-cycle expected step/done/steps_left are
// queued when a command is issued and compared as the DUT runs.
module tb_step_gen;
  localparam int CNT_W     = 32;
  localparam int STEP_W    = 31;
  localparam int DIR_SETUP = 4;

  typedef struct {
    logic              step;
    logic              done;
    logic [STEP_W-1:0] left;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];
  logic done_flag;

  step_gen_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) bus ();

  step_gen #(.CNT_W(CNT_W), .STEP_W(STEP_W), .DIR_SETUP(DIR_SETUP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic s, input int left);
    exp_t e;
    e.step    = s;
    e.done    = done_flag;
    e.left    = STEP_W'(left);
    done_flag = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int k);
    for (int i = 0; i < k; i++) push_entry(1'b0, 0);
  endtask

  task automatic push_setup(input int n);
    for (int i = 0; i < DIR_SETUP; i++) push_entry(1'b0, n);
  endtask

  task automatic push_run(input int p, input int n);
    int pe;
    pe = (p < 2) ? 2 : p;
    for (int s = 0; s < n; s++)
      for (int ph = 0; ph < pe; ph++)
        push_entry(ph < (pe >> 1), n - s);
    done_flag = 1'b1;
  endtask

  task automatic drain_n(input int k);
    exp_t e;
    for (int i = 0; i < k && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.step !== e.step) $display("FAIL sb_step @%0t: got %b expected %b", $time, bus.step, e.step);
      else n_pass++;
      n_checks++;
      if (bus.done !== e.done) $display("FAIL sb_done @%0t: got %b expected %b", $time, bus.done, e.done);
      else n_pass++;
      n_checks++;
      if (bus.steps_left !== e.left) $display("FAIL sb_left @%0t: got %0d expected %0d", $time, bus.steps_left, e.left);
      else n_pass++;
      cyc();
    end
  endtask

  task automatic drain_all();
    drain_n(exp_q.size());
  endtask

  task automatic drive_cmd(input int p, input int n, input logic d);
    bus.cmd_valid  = 1'b1;
    bus.cmd_period = CNT_W'(p);
    bus.cmd_steps  = STEP_W'(n);
    bus.cmd_dir    = d;
  endtask

  task automatic send_cmd(input int p, input int n, input logic d);
    drive_cmd(p, n, d);
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_period = '0; bus.cmd_steps = '0;
    bus.cmd_dir = 1'b0; bus.abort = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if ({bus.step, bus.dir, bus.done, bus.busy, bus.cmd_ready} !== 5'b00001)
      $display("FAIL reset_flags: got %b expected 00001", {bus.step, bus.dir, bus.done, bus.busy, bus.cmd_ready});
    else n_pass++;
    n_checks++;
    if (bus.steps_left !== '0) $display("FAIL reset_left: got %0d expected 0", bus.steps_left);
    else n_pass++;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    send_cmd(6, 3, 1'b0);
    push_idle(1); push_run(6, 3); push_idle(1);
    drain_all();
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_cmd(4, 2, 1'b0);
    drive_cmd(2, 3, 1'b0);
    push_idle(1); push_run(4, 2); push_run(2, 3); push_idle(1);
    drain_n(1);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL b2b_ready_free: got %b expected 1", bus.cmd_ready);
    else n_pass++;
    drain_n(1);
    bus.cmd_valid  = 1'b0;
    bus.cmd_period = CNT_W'(9);
    bus.cmd_steps  = STEP_W'(7);
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (bus.cmd_ready !== 1'b0) $display("FAIL b2b_ready_pending: got %b expected 0", bus.cmd_ready);
      else n_pass++;
      drain_n(1);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL b2b_ready_after_load: got %b expected 1", bus.cmd_ready);
    else n_pass++;
    drain_all();
  endtask

  task automatic test_dir_setup();
    send_cmd(4, 2, 1'b1);
    n_checks++;
    if (bus.dir !== 1'b0) $display("FAIL setup_dir_before: got %b expected 0", bus.dir);
    else n_pass++;
    push_idle(1); push_setup(2); push_run(4, 2); push_idle(1);
    drain_n(1);
    n_checks++;
    if (bus.dir !== 1'b1) $display("FAIL setup_dir_at_load: got %b expected 1", bus.dir);
    else n_pass++;
    drain_all();
  endtask

  task automatic test_short_period();
    send_cmd(0, 2, 1'b1);
    push_idle(1); push_run(0, 2); push_idle(1);
    drain_all();
    send_cmd(1, 1, 1'b1);
    push_idle(1); push_run(1, 1); push_idle(1);
    drain_all();
    send_cmd(5, 0, 1'b0);
    push_idle(1); done_flag = 1'b1; push_idle(2);
    drain_all();
    n_checks++;
    if (bus.dir !== 1'b1) $display("FAIL zero_steps_dir: got %b expected 1", bus.dir);
    else n_pass++;
  endtask

  task automatic test_abort();
    send_cmd(4, 5, 1'b1);
    drive_cmd(2, 1, 1'b0);
    push_idle(1); push_run(4, 5);
    drain_n(2);
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (bus.cmd_ready !== 1'b0) $display("FAIL abort_pending: got %b expected 0", bus.cmd_ready);
    else n_pass++;
    drain_n(4);
    n_checks++;
    if (bus.step !== 1'b1) $display("FAIL abort_pre_step: got %b expected 1", bus.step);
    else n_pass++;
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    n_checks++;
    if ({bus.step, bus.busy, bus.done, bus.cmd_ready, bus.dir} !== 5'b00011)
      $display("FAIL abort_flags: got %b expected 00011", {bus.step, bus.busy, bus.done, bus.cmd_ready, bus.dir});
    else n_pass++;
    n_checks++;
    if (bus.steps_left !== '0) $display("FAIL abort_left: got %0d expected 0", bus.steps_left);
    else n_pass++;
    cyc();
    n_checks++;
    if ({bus.step, bus.busy, bus.done} !== 3'b000)
      $display("FAIL abort_flushed: got %b expected 000", {bus.step, bus.busy, bus.done});
    else n_pass++;
    exp_q.delete();
    done_flag = 1'b0;
    send_cmd(2, 2, 1'b1);
    push_idle(1); push_run(2, 2); push_idle(1);
    drain_all();
  endtask

  task automatic test_async_reset();
    send_cmd(6, 3, 1'b1);
    cyc();
    n_checks++;
    if (bus.step !== 1'b1) $display("FAIL areset_pre_step: got %b expected 1", bus.step);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.step, bus.dir, bus.done, bus.busy, bus.cmd_ready} !== 5'b00001)
      $display("FAIL areset_flags: got %b expected 00001", {bus.step, bus.dir, bus.done, bus.busy, bus.cmd_ready});
    else n_pass++;
    n_checks++;
    if (bus.steps_left !== '0) $display("FAIL areset_left: got %0d expected 0", bus.steps_left);
    else n_pass++;
    cyc();
    reset = 1'b0;
    send_cmd(2, 1, 1'b0);
    push_idle(1); push_run(2, 1); push_idle(1);
    drain_all();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    done_flag = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_dir_setup();
    test_short_period();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
